// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit two's-complement add/sub with carry rippling one CW-bit chunk per stage,
// valid/ready on both sides and a single global advance that stalls the whole pipe.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int CW = WIDTH / STAGES;
  if (WIDTH < 2 || STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad
    $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
  end
  logic             adv;
  logic [WIDTH-1:0] ra [STAGES];
  logic [WIDTH-1:0] rb [STAGES];
  logic [WIDTH-1:0] rr [STAGES];
  logic             rc [STAGES];
  logic             rv [STAGES];
  logic             rs [STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = rv[STAGES-1];
  assign s         = rr[STAGES-1];
  assign cout      = rc[STAGES-1];
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] ia, ib, ir, nr;
    logic             ic, iv, is;
    logic [CW:0]      sum;
    // operands travel whole so the MSBs are still at hand for overflow in the last stage
    if (k == 0) begin : g_src
      assign ia = a;
      assign ib = b ^ {WIDTH{sub}};
      assign ir = '0;
      assign ic = sub;
      assign iv = in_valid;
      assign is = sub;
    end else begin : g_src
      assign ia = ra[k-1];
      assign ib = rb[k-1];
      assign ir = rr[k-1];
      assign ic = rc[k-1];
      assign iv = rv[k-1];
      assign is = rs[k-1];
    end
    assign sum = {1'b0, ia[k*CW +: CW]} + {1'b0, ib[k*CW +: CW]} + (CW+1)'(ic);
    always_comb begin
      nr = ir;
      nr[k*CW +: CW] = sum[CW-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rv[k] <= 1'b0;
        rs[k] <= 1'b0;
        rc[k] <= 1'b0;
        ra[k] <= '0;
        rb[k] <= '0;
        rr[k] <= '0;
      end else if (adv) begin
        rv[k] <= iv;
        rs[k] <= is;
        rc[k] <= sum[CW];
        ra[k] <= ia;
        rb[k] <= ib;
        rr[k] <= nr;
      end
    end
    if (k == STAGES - 1) begin : g_flags
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf  <= 1'b0;
          zero <= 1'b0;
        end else if (adv) begin
          ovf  <= (ia[WIDTH-1] == ib[WIDTH-1]) && (nr[WIDTH-1] != ia[WIDTH-1]);
          zero <= nr == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed vectors for the 16/4 build plus streaming, reset and 8/1, 32/8 sweeps.
module tb_pipelined_addsub;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic iv16 = 0, ir16, sub16 = 0, ov16, or16 = 1, co16, of16, z16;
  logic [15:0] a16 = 0, b16 = 0, s16;
  logic iv8 = 0, ir8, sub8 = 0, ov8, or8 = 1, co8, of8, z8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic iv32 = 0, ir32, sub32 = 0, ov32, or32 = 1, co32, of32, z32;
  logic [31:0] a32 = 0, b32 = 0, s32;

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u16 (.clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .s(s16), .cout(co16), .ovf(of16), .zero(z16));
  pipelined_addsub #(.WIDTH(8), .STAGES(1)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .s(s8), .cout(co8), .ovf(of8), .zero(z8));
  pipelined_addsub #(.WIDTH(32), .STAGES(8)) u32 (.clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .s(s32), .cout(co32), .ovf(of32), .zero(z32));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [18:0] model(input logic sb, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] bx;
    logic [16:0] t;
    bx = y ^ {16{sb}};
    t = {1'b0, x} + {1'b0, bx} + 17'(sb);
    return {t[15:0] == 16'h0, (x[15] == bx[15]) && (t[15] != x[15]), t[16], t[15:0]};
  endfunction

  task automatic xact16(input logic sb, input logic [15:0] x, input logic [15:0] y, output int lat);
    @(negedge clk);
    a16 = x; b16 = y; sub16 = sb; iv16 = 1;
    @(posedge clk);
    #1 iv16 = 0;
    lat = 1;
    while (!ov16 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  typedef struct {
    logic sb; logic [15:0] x, y;
    logic [15:0] es; logic ec, eo, ez;
  } vec_t;
  typedef struct { logic sb; logic [15:0] x, y; } op_t;

  vec_t tv[8];
  op_t  ops[8];
  logic [6:0]  pat = 7'b1011001;
  logic [18:0] e;
  logic [15:0] held;
  logic        stall;
  int lat, sent, got, extra;

  initial begin
    tv[0] = '{0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0};
    tv[1] = '{0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1};
    tv[2] = '{0, 16'h00FF, 16'h0F01, 16'h1000, 0, 0, 0};
    tv[3] = '{1, 16'h0005, 16'h0005, 16'h0000, 1, 0, 1};
    tv[4] = '{1, 16'h0000, 16'h0001, 16'hFFFF, 0, 0, 0};
    tv[5] = '{1, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0};
    tv[6] = '{0, 16'h8000, 16'h8000, 16'h0000, 1, 1, 1};
    tv[7] = '{1, 16'h1234, 16'h0234, 16'h1000, 1, 0, 0};
    ops[0] = '{0, 16'h1234, 16'h1111};
    ops[1] = '{1, 16'h0100, 16'h0200};
    ops[2] = '{0, 16'h7FFF, 16'h7FFF};
    ops[3] = '{1, 16'h8000, 16'h7FFF};
    ops[4] = '{0, 16'hFFFF, 16'hFFFF};
    ops[5] = '{1, 16'hABCD, 16'hABCD};
    ops[6] = '{0, 16'h0F0F, 16'hF0F1};
    ops[7] = '{1, 16'h0003, 16'h0007};

    #1;
    chk("reset_out_valid", 32'(ov16), 0);
    chk("reset_s", 32'(s16), 0);
    chk("reset_in_ready", 32'(ir16), 1);
    repeat (2) @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      xact16(tv[i].sb, tv[i].x, tv[i].y, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 4);
      chk($sformatf("v%0d_s", i), 32'(s16), 32'(tv[i].es));
      chk($sformatf("v%0d_cout", i), 32'(co16), 32'(tv[i].ec));
      chk($sformatf("v%0d_ovf", i), 32'(of16), 32'(tv[i].eo));
      chk($sformatf("v%0d_zero", i), 32'(z16), 32'(tv[i].ez));
    end
    repeat (2) @(posedge clk);

    sent = 0; got = 0; stall = 0; held = 0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      @(negedge clk);
      if (stall) chk("stall_hold_s", 32'(s16), 32'(held));
      or16 = pat[c % 7];
      iv16 = sent < 8;
      if (sent < 8) begin
        a16 = ops[sent].x; b16 = ops[sent].y; sub16 = ops[sent].sb;
      end
      #1;
      chk("stream_in_ready", 32'(ir16), 32'(!ov16 || or16));
      if (ov16 && or16) begin
        e = model(ops[got].sb, ops[got].x, ops[got].y);
        chk($sformatf("stream%0d_s", got), 32'(s16), 32'(e[15:0]));
        chk($sformatf("stream%0d_cout", got), 32'(co16), 32'(e[16]));
        chk($sformatf("stream%0d_ovf", got), 32'(of16), 32'(e[17]));
        chk($sformatf("stream%0d_zero", got), 32'(z16), 32'(e[18]));
        got++;
      end
      if (iv16 && ir16) sent++;
      stall = ov16 && !or16;
      held = s16;
    end
    @(negedge clk);
    iv16 = 0; or16 = 1;
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1 if (ov16) extra++;
    end
    chk("stream_count", 32'(got), 8);
    chk("stream_no_extra", 32'(extra), 0);

    @(negedge clk);
    or16 = 0; iv16 = 1; a16 = 16'h1111; b16 = 16'h2222; sub16 = 0;
    repeat (3) @(posedge clk);
    #1 iv16 = 0;
    @(posedge clk);
    #1 chk("pre_reset_valid", 32'(ov16), 1);
    chk("pre_reset_s", 32'(s16), 32'h3333);
    #2 rst_n = 0;
    #1;
    chk("async_reset_valid", 32'(ov16), 0);
    chk("async_reset_s", 32'(s16), 0);
    chk("async_reset_in_ready", 32'(ir16), 1);
    @(negedge clk);
    rst_n = 1; or16 = 1;
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1 if (ov16) extra++;
    end
    chk("no_stale_after_reset", 32'(extra), 0);
    xact16(0, 16'h0002, 16'h0003, lat);
    chk("post_reset_latency", 32'(lat), 4);
    chk("post_reset_s", 32'(s16), 32'h0005);

    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; sub8 = 0; iv8 = 1;
    @(posedge clk);
    #1 iv8 = 0;
    chk("w8_valid_after_accept", 32'(ov8), 1);
    chk("w8_s", 32'(s8), 32'h80);
    chk("w8_ovf", 32'(of8), 1);
    chk("w8_cout", 32'(co8), 0);

    @(negedge clk);
    a32 = 32'hFFFF_FFFF; b32 = 32'h1; sub32 = 0; iv32 = 1;
    @(posedge clk);
    #1 iv32 = 0;
    lat = 1;
    while (!ov32 && lat < 30) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("w32_latency", 32'(lat), 8);
    chk("w32_s", s32, 0);
    chk("w32_cout", 32'(co32), 1);
    chk("w32_zero", 32'(z32), 1);
    chk("w32_ovf", 32'(of32), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
